shim_spi_sts_sync_rx: RTL and testbench



---
 rtl/shim_sts_sync_pkg.sv | 15 +
 rtl/shim_spi_sts_sync_rx_if.sv | 27 ++
 rtl/shim_sts_toggle_sync.sv | 27 ++
 rtl/shim_spi_sts_sync_rx.sv | 130 +++++++++++++
 tb/tb_shim_spi_sts_sync_rx.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/shim_sts_sync_pkg.sv
// Shared types and default constants for the SPI-to-AXI status word receiver.
// The optional stale timeout is enabled with the SHIM_STS_SYNC_TIMEOUT_EN macro.
package shim_sts_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PUBLISH = 2'd2
    } sts_rx_state_t;

    localparam logic [31:0] STS_DOUT_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] STS_FAULT_MASK     = 32'h0000_FF00;
    localparam int          STS_TIMEOUT_CYCLES = 1_000_000;

endpackage

// File: rtl/shim_spi_sts_sync_rx_if.sv
// Status word handshake bundle between the SPI-domain source (master) and the
// AXI-domain receiver (slave), including the published AXI status outputs.
interface shim_spi_sts_sync_rx_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] sts_data;
    logic             sts_req_tgl;
    logic             sts_ack_tgl;
    logic [WIDTH-1:0] sts_data_sync;
    logic             sts_valid;
    logic             sts_seen;
    logic             sts_fault_clr;
    logic [WIDTH-1:0] sts_fault_sticky;
    logic             sts_stale;

    modport master (
        output sts_data, sts_req_tgl, sts_fault_clr,
        input  sts_ack_tgl, sts_data_sync, sts_valid, sts_seen,
               sts_fault_sticky, sts_stale
    );

    modport slave (
        input  sts_data, sts_req_tgl, sts_fault_clr,
        output sts_ack_tgl, sts_data_sync, sts_valid, sts_seen,
               sts_fault_sticky, sts_stale
    );
endinterface

// File: rtl/shim_sts_toggle_sync.sv
// Two-flop synchronizer for a single toggle level crossing into the aclk domain.
module shim_sts_toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic sync1_d, sync1_q;
    logic sync2_d, sync2_q;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;
endmodule

// File: rtl/shim_spi_sts_sync_rx.sv
// AXI-domain receiver for SPI-domain status words: toggle request/ack handshake,
// coherent capture, valid strobe and sticky fault bits. Macro SHIM_STS_SYNC_TIMEOUT_EN adds sts_stale.
module shim_spi_sts_sync_rx
    import shim_sts_sync_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] DOUT_DEFAULT   = WIDTH'(STS_DOUT_DEFAULT),
    parameter logic [WIDTH-1:0] FAULT_MASK     = WIDTH'(STS_FAULT_MASK),
    parameter int               TIMEOUT_CYCLES = STS_TIMEOUT_CYCLES
) (
    input  logic               aclk,
    input  logic               areset,
    shim_spi_sts_sync_rx_if.slave sts
);
    sts_rx_state_t    state_d, state_q;
    logic             req_sync;
    logic             req_pend;
    logic             load;
    logic [WIDTH-1:0] shadow_d, shadow_q;
    logic [WIDTH-1:0] data_sync_d, data_sync_q;
    logic             valid_d, valid_q;
    logic             req_seen_d, req_seen_q;
    logic             ack_d, ack_q;
    logic             seen_d, seen_q;
    logic [WIDTH-1:0] sticky_d, sticky_q;

    shim_sts_toggle_sync u_req_sync (
        .clk (aclk),
        .rst (areset),
        .d   (sts.sts_req_tgl),
        .q   (req_sync)
    );

    assign req_pend = req_sync ^ req_seen_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_pend) state_d = CAPTURE;
            CAPTURE: state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything published is registered on the CAPTURE->PUBLISH edge so the
    // new word, ack and sticky bits are all visible while sts_valid is high.
    always_comb begin
        load        = (state_q == CAPTURE);
        shadow_d    = load ? sts.sts_data : shadow_q;
        data_sync_d = load ? sts.sts_data : data_sync_q;
        valid_d     = load;
        req_seen_d  = load ? req_sync : req_seen_q;
        ack_d       = load ? req_sync : ack_q;
        seen_d      = seen_q | load;
        sticky_d    = sts.sts_fault_clr ? '0 : sticky_q;
        if (load)
            sticky_d = sticky_d | (sts.sts_data & FAULT_MASK);
        else if (state_q == PUBLISH && sts.sts_fault_clr)
            sticky_d = shadow_q & FAULT_MASK;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            data_sync_q <= DOUT_DEFAULT;
            valid_q     <= 1'b0;
            req_seen_q  <= 1'b0;
            ack_q       <= 1'b0;
            seen_q      <= 1'b0;
            sticky_q    <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            data_sync_q <= data_sync_d;
            valid_q     <= valid_d;
            req_seen_q  <= req_seen_d;
            ack_q       <= ack_d;
            seen_q      <= seen_d;
            sticky_q    <= sticky_d;
        end
    end

    assign sts.sts_ack_tgl      = ack_q;
    assign sts.sts_data_sync    = data_sync_q;
    assign sts.sts_valid        = valid_q;
    assign sts.sts_seen         = seen_q;
    assign sts.sts_fault_sticky = sticky_q;

`ifdef SHIM_STS_SYNC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             stale_d, stale_q;

    // Saturating age counter; a publish restarts it and clears the stale flag.
    always_comb begin
        cnt_d   = cnt_q;
        stale_d = stale_q;
        if (load) begin
            cnt_d   = '0;
            stale_d = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX)
                stale_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end

    assign sts.sts_stale = stale_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign sts.sts_stale  = 1'b0;
`endif

endmodule

// File: tb/tb_shim_spi_sts_sync_rx.sv
// Directed self-checking bench for shim_spi_sts_sync_rx (WIDTH=32, TIMEOUT_CYCLES=1000).
// Stale expectations follow SHIM_STS_SYNC_TIMEOUT_EN.
module tb_shim_spi_sts_sync_rx;

    logic aclk;
    logic areset;
    int   total;
    int   bad;

`ifdef SHIM_STS_SYNC_TIMEOUT_EN
    localparam logic EXP_STALE = 1'b1;
`else
    localparam logic EXP_STALE = 1'b0;
`endif

    shim_spi_sts_sync_rx_if #(.WIDTH(32)) sts_if ();

    shim_spi_sts_sync_rx #(
        .WIDTH          (32),
        .DOUT_DEFAULT   (32'h0000_0000),
        .FAULT_MASK     (32'h0000_FF00),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .sts    (sts_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Presents a word, flips the request and returns in the PUBLISH cycle
    // (the negedge where sts_valid is first seen high), or with ok=0 on timeout.
    task automatic send_word(input logic [31:0] w, output bit ok);
        @(negedge aclk);
        sts_if.sts_data = w;
        @(negedge aclk);
        sts_if.sts_req_tgl = ~sts_if.sts_req_tgl;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge aclk);
            if (sts_if.sts_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit saw_valid;
        sts_if.sts_data      = 32'h0;
        sts_if.sts_req_tgl   = 1'b0;
        sts_if.sts_fault_clr = 1'b0;
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (sts_if.sts_valid !== 1'b0) saw_valid = 1'b1;
        end
        total++; if (saw_valid) begin bad++; $display("[TB] FAIL reset_valid: valid pulsed with no traffic"); end
        total++; if (sts_if.sts_data_sync !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want %h", sts_if.sts_data_sync, 32'h0); end
        total++; if (sts_if.sts_seen !== 1'b0) begin bad++; $display("[TB] FAIL reset_seen: got %b want 0", sts_if.sts_seen); end
        total++; if (sts_if.sts_ack_tgl !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", sts_if.sts_ack_tgl); end
        total++; if (sts_if.sts_fault_sticky !== 32'h0) begin bad++; $display("[TB] FAIL reset_sticky: got %h want 0", sts_if.sts_fault_sticky); end
        total++; if (sts_if.sts_stale !== 1'b0) begin bad++; $display("[TB] FAIL reset_stale: got %b want 0", sts_if.sts_stale); end
    endtask

    task automatic test_latency();
        bit early;
        @(negedge aclk);
        sts_if.sts_data = 32'h1234_0056;
        @(negedge aclk);
        sts_if.sts_req_tgl = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            if (sts_if.sts_valid !== 1'b0) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("[TB] FAIL lat_early: valid before edge E3"); end
        @(negedge aclk);
        total++; if (sts_if.sts_valid !== 1'b1) begin bad++; $display("[TB] FAIL lat_valid: got %b want 1", sts_if.sts_valid); end
        total++; if (sts_if.sts_data_sync !== 32'h1234_0056) begin bad++; $display("[TB] FAIL lat_data: got %h want %h", sts_if.sts_data_sync, 32'h1234_0056); end
        total++; if (sts_if.sts_ack_tgl !== 1'b1) begin bad++; $display("[TB] FAIL lat_ack: got %b want 1", sts_if.sts_ack_tgl); end
        total++; if (sts_if.sts_seen !== 1'b1) begin bad++; $display("[TB] FAIL lat_seen: got %b want 1", sts_if.sts_seen); end
        total++; if (sts_if.sts_fault_sticky !== 32'h0) begin bad++; $display("[TB] FAIL lat_sticky: got %h want 0", sts_if.sts_fault_sticky); end
        @(negedge aclk);
        total++; if (sts_if.sts_valid !== 1'b0) begin bad++; $display("[TB] FAIL lat_pulse: valid got %b want 0", sts_if.sts_valid); end
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_fault_accum();
        bit ok;
        send_word(32'h0000_0300, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL acc_w1_timeout: no valid for 00000300"); end
        total++; if (sts_if.sts_ack_tgl !== 1'b0) begin bad++; $display("[TB] FAIL acc_w1_ack: got %b want 0", sts_if.sts_ack_tgl); end
        send_word(32'h0000_0400, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL acc_w2_timeout: no valid for 00000400"); end
        @(negedge aclk);
        total++; if (sts_if.sts_fault_sticky !== 32'h0000_0700) begin bad++; $display("[TB] FAIL acc_sticky: got %h want %h", sts_if.sts_fault_sticky, 32'h0000_0700); end
        total++; if (sts_if.sts_data_sync !== 32'h0000_0400) begin bad++; $display("[TB] FAIL acc_data: got %h want %h", sts_if.sts_data_sync, 32'h0000_0400); end
        sts_if.sts_fault_clr = 1'b1;
        @(negedge aclk);
        sts_if.sts_fault_clr = 1'b0;
        total++; if (sts_if.sts_fault_sticky !== 32'h0) begin bad++; $display("[TB] FAIL acc_clear: got %h want 0", sts_if.sts_fault_sticky); end
        @(negedge aclk);
    endtask

    task automatic test_clr_on_publish();
        bit ok;
        send_word(32'h0000_0200, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL clrpub_w1_timeout: no valid for 00000200"); end
        send_word(32'h0000_0100, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL clrpub_w2_timeout: no valid for 00000100"); end
        total++; if (sts_if.sts_fault_sticky !== 32'h0000_0300) begin bad++; $display("[TB] FAIL clrpub_before: got %h want %h", sts_if.sts_fault_sticky, 32'h0000_0300); end
        sts_if.sts_fault_clr = 1'b1;
        @(negedge aclk);
        sts_if.sts_fault_clr = 1'b0;
        total++; if (sts_if.sts_fault_sticky !== 32'h0000_0100) begin bad++; $display("[TB] FAIL clrpub_after: got %h want %h", sts_if.sts_fault_sticky, 32'h0000_0100); end
        @(negedge aclk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int pulses;
        send_word(32'h0000_1100, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_w1_timeout: no valid for 00001100"); end
        // flip again during PUBLISH: must stay pending and be served afterwards
        sts_if.sts_data    = 32'h0000_2200;
        sts_if.sts_req_tgl = ~sts_if.sts_req_tgl;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge aclk);
            if (sts_if.sts_valid === 1'b1) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("[TB] FAIL b2b_pulses: got %0d want 1", pulses); end
        total++; if (sts_if.sts_data_sync !== 32'h0000_2200) begin bad++; $display("[TB] FAIL b2b_data: got %h want %h", sts_if.sts_data_sync, 32'h0000_2200); end
        total++; if (sts_if.sts_ack_tgl !== sts_if.sts_req_tgl) begin bad++; $display("[TB] FAIL b2b_ack: got %b want %b", sts_if.sts_ack_tgl, sts_if.sts_req_tgl); end
        total++; if (sts_if.sts_fault_sticky !== 32'h0000_3300) begin bad++; $display("[TB] FAIL b2b_sticky: got %h want %h", sts_if.sts_fault_sticky, 32'h0000_3300); end
    endtask

    task automatic test_reset_mid_capture();
        int pulses;
        areset = 1'b1;
        sts_if.sts_req_tgl = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        repeat (3) @(negedge aclk);
        sts_if.sts_data = 32'hABCD_0500;
        @(negedge aclk);
        sts_if.sts_req_tgl = 1'b1;
        repeat (3) @(negedge aclk);
        // FSM now in CAPTURE
        areset = 1'b1;
        #1;
        total++; if (sts_if.sts_data_sync !== 32'h0 || sts_if.sts_valid !== 1'b0 || sts_if.sts_ack_tgl !== 1'b0 ||
                     sts_if.sts_seen !== 1'b0 || sts_if.sts_fault_sticky !== 32'h0) begin
            bad++;
            $display("[TB] FAIL mid_reset_vals: data=%h valid=%b ack=%b seen=%b sticky=%h want all zero",
                     sts_if.sts_data_sync, sts_if.sts_valid, sts_if.sts_ack_tgl, sts_if.sts_seen, sts_if.sts_fault_sticky);
        end
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge aclk);
            if (sts_if.sts_valid === 1'b1) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("[TB] FAIL mid_pulses: got %0d want 1", pulses); end
        total++; if (sts_if.sts_data_sync !== 32'hABCD_0500) begin bad++; $display("[TB] FAIL mid_data: got %h want %h", sts_if.sts_data_sync, 32'hABCD_0500); end
        total++; if (sts_if.sts_ack_tgl !== 1'b1) begin bad++; $display("[TB] FAIL mid_ack: got %b want 1", sts_if.sts_ack_tgl); end
        total++; if (sts_if.sts_fault_sticky !== 32'h0000_0500) begin bad++; $display("[TB] FAIL mid_sticky: got %h want %h", sts_if.sts_fault_sticky, 32'h0000_0500); end
    endtask

    task automatic test_timeout();
        bit ok;
        send_word(32'h0000_0001, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL to_w1_timeout: no valid for 00000001"); end
        repeat (990) @(negedge aclk);
        total++; if (sts_if.sts_stale !== 1'b0) begin bad++; $display("[TB] FAIL to_early: stale got %b want 0", sts_if.sts_stale); end
        repeat (15) @(negedge aclk);
        total++; if (sts_if.sts_stale !== EXP_STALE) begin bad++; $display("[TB] FAIL to_set: stale got %b want %b", sts_if.sts_stale, EXP_STALE); end
        send_word(32'h0000_0002, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL to_w2_timeout: no valid for 00000002"); end
        total++; if (sts_if.sts_stale !== 1'b0) begin bad++; $display("[TB] FAIL to_clear: stale got %b want 0", sts_if.sts_stale); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        areset = 1'b1;
        sts_if.sts_data      = 32'h0;
        sts_if.sts_req_tgl   = 1'b0;
        sts_if.sts_fault_clr = 1'b0;
        test_reset();
        test_latency();
        test_fault_accum();
        test_clr_on_publish();
        test_back_to_back();
        test_reset_mid_capture();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
